id_hazard_unit: RTL and testbench

Parametrised decode-stage holding register with a generalised forwarding and load-use hazard network. It sits between fetch and execute and replaces the fixed two-operand, three-source forwarding logic of the current decode stage. It supports:
- N register read ports and M downstream forwarding stages;
- a configurable point at which memory results become forwardable;
- valid/ready handshakes on both sides;
- a saturating hazard-stall counter for performance debug.

---
 rtl/id_hazard_unit_pkg.sv | 12 +
 rtl/id_hazard_unit_fwd_mux.sv | 47 ++++
 rtl/id_hazard_unit.sv | 106 ++++++++++
 tb/tb_id_hazard_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_unit_pkg.sv
// Shared decode-stage constants: destination-source codes carried by each
// downstream stage alongside its result.
package id_hazard_unit_pkg;

    localparam int DEST_SRC_NONE = 0;
    localparam int DEST_SRC_ALU  = 1;
    localparam int DEST_SRC_MEM  = 2;

    localparam int RD_PORTS_MAX   = 4;
    localparam int FWD_STAGES_MAX = 4;

endpackage

// File: rtl/id_hazard_unit_fwd_mux.sv
// One read port's forwarding network: youngest matching stage wins, and a
// MEM result still too young to be forwardable becomes a hazard instead.
module id_fwd_mux
    import id_hazard_unit_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int REG_IDX_W  = 5,
    parameter int DEST_SRC_W = 2,
    parameter int FWD_STAGES = 3,
    parameter int MEM_STAGE  = 1
) (
    input  logic [REG_IDX_W-1:0]             rs_idx,
    input  logic                             rs_use,
    input  logic [WORD_W-1:0]                rf_data,
    input  logic [FWD_STAGES*REG_IDX_W-1:0]  fwd_reg,
    input  logic [FWD_STAGES*DEST_SRC_W-1:0] fwd_src,
    input  logic [FWD_STAGES*WORD_W-1:0]     fwd_data,
    output logic [WORD_W-1:0]                rs_data,
    output logic                             hazard
);

    logic [DEST_SRC_W-1:0] src;

    // Walk oldest to youngest so a younger match overwrites an older one,
    // including replacing forwarded data with a hazard.
    always_comb begin
        rs_data = rf_data;
        hazard  = 1'b0;
        src     = '0;
        if (rs_use && rs_idx != '0) begin
            for (int s = FWD_STAGES - 1; s >= 0; s--) begin
                src = fwd_src[s*DEST_SRC_W +: DEST_SRC_W];
                if (fwd_reg[s*REG_IDX_W +: REG_IDX_W] == rs_idx &&
                    src != DEST_SRC_W'(DEST_SRC_NONE)) begin
                    if (src == DEST_SRC_W'(DEST_SRC_MEM) && s < MEM_STAGE) begin
                        hazard  = 1'b1;
                        rs_data = rf_data;
                    end else begin
                        hazard  = 1'b0;
                        rs_data = fwd_data[s*WORD_W +: WORD_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/id_hazard_unit.sv
// Decode holding register with valid/ready on both sides, per-port operand
// forwarding, load-use bubble insertion and a saturating stall counter.
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int REG_IDX_W  = 5,
    parameter int DEST_SRC_W = 2,
    parameter int RD_PORTS   = 2,
    parameter int FWD_STAGES = 3,
    parameter int MEM_STAGE  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic                             i_flush,
    input  logic                             i_valid,
    output logic                             o_ready,
    input  logic [ADDR_W-1:0]                i_pc,
    input  logic [INSTR_W-1:0]               i_instr,
    output logic [ADDR_W-1:0]                o_pc,
    output logic [INSTR_W-1:0]               o_instr,
    input  logic [RD_PORTS*REG_IDX_W-1:0]    i_rs_idx,
    input  logic [RD_PORTS-1:0]              i_rs_use,
    input  logic [RD_PORTS*WORD_W-1:0]       i_rf_data,
    input  logic [FWD_STAGES*REG_IDX_W-1:0]  i_fwd_reg,
    input  logic [FWD_STAGES*DEST_SRC_W-1:0] i_fwd_src,
    input  logic [FWD_STAGES*WORD_W-1:0]     i_fwd_data,
    output logic [RD_PORTS*WORD_W-1:0]       o_rs_data,
    output logic                             o_hazard,
    output logic [RD_PORTS-1:0]              o_hazard_port,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic [CNT_W-1:0]                 o_stall_cnt
);

    if (RD_PORTS < 1 || RD_PORTS > RD_PORTS_MAX) begin : g_bad_rd_ports
        $error("id_hazard_unit: RD_PORTS must be 1..4");
    end
    if (FWD_STAGES < 1 || FWD_STAGES > FWD_STAGES_MAX) begin : g_bad_fwd_stages
        $error("id_hazard_unit: FWD_STAGES must be 1..4");
    end
    if (MEM_STAGE < 0 || MEM_STAGE > FWD_STAGES) begin : g_bad_mem_stage
        $error("id_hazard_unit: MEM_STAGE must be 0..FWD_STAGES");
    end

    logic               r_valid;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [RD_PORTS-1:0] port_hz;
    logic               fire;
    logic               load;

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
        id_fwd_mux #(
            .WORD_W     (WORD_W),
            .REG_IDX_W  (REG_IDX_W),
            .DEST_SRC_W (DEST_SRC_W),
            .FWD_STAGES (FWD_STAGES),
            .MEM_STAGE  (MEM_STAGE)
        ) u_mux (
            .rs_idx   (i_rs_idx[p*REG_IDX_W +: REG_IDX_W]),
            .rs_use   (i_rs_use[p]),
            .rf_data  (i_rf_data[p*WORD_W +: WORD_W]),
            .fwd_reg  (i_fwd_reg),
            .fwd_src  (i_fwd_src),
            .fwd_data (i_fwd_data),
            .rs_data  (o_rs_data[p*WORD_W +: WORD_W]),
            .hazard   (port_hz[p])
        );
    end

    assign o_hazard_port = r_valid ? port_hz : '0;
    assign o_hazard      = |o_hazard_port;
    assign o_valid       = r_valid & ~o_hazard;
    assign fire          = o_valid & i_ready;
    assign o_ready       = ~clr & ~i_flush & (~r_valid | fire);
    assign load          = i_valid & o_ready;
    assign o_pc          = r_pc;
    assign o_instr       = r_instr;
    assign o_stall_cnt   = r_stall_cnt;

    // Flush cannot coincide with a load because o_ready is low during it.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_instr     <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (load) begin
                r_valid <= 1'b1;
                r_pc    <= i_pc;
                r_instr <= i_instr;
            end else if (fire || i_flush) begin
                r_valid <= 1'b0;
            end
            if (o_hazard && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Directed bench for id_hazard_unit: handshake, forwarding priority,
// load-use bubbles, backpressure, flush/reset and counter saturation.
module tb_id_hazard_unit;

    localparam int WW = 32, AW = 32, IW = 32, RW = 5, SW = 2, NP = 2, NS = 3;

    logic clk = 0, clr, i_flush, i_valid, i_ready;
    logic [AW-1:0] i_pc;
    logic [IW-1:0] i_instr;
    logic [NP*RW-1:0] i_rs_idx;
    logic [NP-1:0] i_rs_use;
    logic [NP*WW-1:0] i_rf_data;
    logic [NS*RW-1:0] i_fwd_reg;
    logic [NS*SW-1:0] i_fwd_src;
    logic [NS*WW-1:0] i_fwd_data;

    logic o_ready, o_hazard, o_valid;
    logic [AW-1:0] o_pc;
    logic [IW-1:0] o_instr;
    logic [NP*WW-1:0] o_rs_data;
    logic [NP-1:0] o_hazard_port;
    logic [15:0] o_stall_cnt;

    logic s_ready, s_hazard, s_valid;
    logic [AW-1:0] s_pc;
    logic [IW-1:0] s_instr;
    logic [NP*WW-1:0] s_rs_data;
    logic [NP-1:0] s_hazard_port;
    logic [3:0] s_stall_cnt;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    id_hazard_unit dut (
        .clk(clk), .clr(clr), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_instr(i_instr), .o_pc(o_pc), .o_instr(o_instr),
        .i_rs_idx(i_rs_idx), .i_rs_use(i_rs_use), .i_rf_data(i_rf_data),
        .i_fwd_reg(i_fwd_reg), .i_fwd_src(i_fwd_src), .i_fwd_data(i_fwd_data),
        .o_rs_data(o_rs_data), .o_hazard(o_hazard), .o_hazard_port(o_hazard_port),
        .o_valid(o_valid), .i_ready(i_ready), .o_stall_cnt(o_stall_cnt)
    );

    id_hazard_unit #(.CNT_W(4)) dut_small (
        .clk(clk), .clr(clr), .i_flush(i_flush), .i_valid(i_valid), .o_ready(s_ready),
        .i_pc(i_pc), .i_instr(i_instr), .o_pc(s_pc), .o_instr(s_instr),
        .i_rs_idx(i_rs_idx), .i_rs_use(i_rs_use), .i_rf_data(i_rf_data),
        .i_fwd_reg(i_fwd_reg), .i_fwd_src(i_fwd_src), .i_fwd_data(i_fwd_data),
        .o_rs_data(s_rs_data), .o_hazard(s_hazard), .o_hazard_port(s_hazard_port),
        .o_valid(s_valid), .i_ready(i_ready), .o_stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_stage(input int s, input logic [RW-1:0] r,
                             input logic [SW-1:0] src, input logic [WW-1:0] d);
        i_fwd_reg[s*RW +: RW]   = r;
        i_fwd_src[s*SW +: SW]   = src;
        i_fwd_data[s*WW +: WW]  = d;
    endtask

    task automatic idle_inputs();
        i_flush = 0; i_valid = 0; i_ready = 1;
        i_pc = '0; i_instr = '0;
        i_rs_idx = '0; i_rs_use = '0; i_rf_data = '0;
        i_fwd_reg = '0; i_fwd_src = '0; i_fwd_data = '0;
    endtask

    task automatic pulse_clr();
        clr = 1; tick(); clr = 0; #1;
    endtask

    // Port 1 reads x7 while stage 0 holds an unforwardable load into x7.
    task automatic setup_load_use();
        i_rs_use = 2'b10;
        i_rs_idx[RW +: RW] = 5'd7;
        set_stage(0, 5'd7, 2'd2, 32'hDEAD);
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1; i_valid = 1; i_pc = 32'h50;
        tick(); tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", o_ready); end
        checks++; if (o_pc !== '0 || o_instr !== '0) begin errors++; $display("FAIL reset_pc_instr got %h/%h exp 0/0", o_pc, o_instr); end
        checks++; if (o_hazard !== 1'b0 || o_stall_cnt !== '0) begin errors++; $display("FAIL reset_hz_cnt got %0b/%0d exp 0/0", o_hazard, o_stall_cnt); end
        i_valid = 0; clr = 0; #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b exp 1", o_ready); end
    endtask

    task automatic test_back_to_back();
        idle_inputs(); pulse_clr();
        i_valid = 1;
        for (int k = 0; k < 4; k++) begin
            i_pc = 32'(4 * k); i_instr = 32'h100 + 32'(k);
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_pc !== 32'(4 * k) || o_instr !== 32'h100 + 32'(k)) begin
                errors++; $display("FAIL b2b_%0d got v=%0b pc=%h instr=%h exp v=1 pc=%h", k, o_valid, o_pc, o_instr, 4 * k);
            end
        end
        i_valid = 0; tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b exp 0", o_valid); end
        checks++; if (o_stall_cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt got %0d exp 0", o_stall_cnt); end
    endtask

    task automatic test_alu_fwd();
        idle_inputs(); pulse_clr();
        i_rs_use = 2'b01; i_rs_idx[0 +: RW] = 5'd5; i_rf_data[0 +: WW] = 32'h5555;
        set_stage(0, 5'd5, 2'd1, 32'hAAAA);
        set_stage(1, 5'd9, 2'd1, 32'hBBBB);
        set_stage(2, 5'd5, 2'd1, 32'hCCCC);
        #1;
        checks++; if (o_rs_data[0 +: WW] !== 32'hAAAA) begin errors++; $display("FAIL fwd_youngest got %h exp aaaa", o_rs_data[0 +: WW]); end
        set_stage(0, 5'd5, 2'd0, 32'hAAAA); #1;
        checks++; if (o_rs_data[0 +: WW] !== 32'hCCCC) begin errors++; $display("FAIL fwd_none_skip got %h exp cccc", o_rs_data[0 +: WW]); end
        set_stage(0, 5'd5, 2'd1, 32'hAAAA);
        i_rs_idx[0 +: RW] = 5'd0; i_rf_data[0 +: WW] = 32'h0;
        set_stage(1, 5'd0, 2'd1, 32'hBBBB); #1;
        checks++; if (o_rs_data[0 +: WW] !== 32'h0) begin errors++; $display("FAIL fwd_x0 got %h exp 0", o_rs_data[0 +: WW]); end
        i_rs_idx[0 +: RW] = 5'd5; i_rs_use = 2'b00; #1;
        checks++; if (o_rs_data[0 +: WW] !== 32'h0) begin errors++; $display("FAIL fwd_nouse got %h exp 0", o_rs_data[0 +: WW]); end
    endtask

    task automatic test_load_use();
        idle_inputs(); pulse_clr();
        setup_load_use();
        set_stage(2, 5'd7, 2'd1, 32'h9999);
        i_valid = 1; i_pc = 32'h20; i_instr = 32'hA0;
        tick();
        i_pc = 32'h24; i_instr = 32'hA4; #1;
        checks++; if (o_hazard !== 1'b1 || o_valid !== 1'b0 || o_ready !== 1'b0) begin
            errors++; $display("FAIL lu_bubble got hz=%0b v=%0b rdy=%0b exp 1/0/0", o_hazard, o_valid, o_ready); end
        checks++; if (o_hazard_port !== 2'b10) begin errors++; $display("FAIL lu_port got %b exp 10", o_hazard_port); end
        tick();
        set_stage(0, 5'd0, 2'd0, 32'h0);
        set_stage(1, 5'd7, 2'd2, 32'h1234); #1;
        checks++; if (o_hazard !== 1'b0 || o_valid !== 1'b1 || o_rs_data[WW +: WW] !== 32'h1234) begin
            errors++; $display("FAIL lu_issue got hz=%0b v=%0b d=%h exp 0/1/1234", o_hazard, o_valid, o_rs_data[WW +: WW]); end
        checks++; if (o_stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", o_stall_cnt); end
        tick();
        checks++; if (o_pc !== 32'h24 || o_valid !== 1'b1) begin errors++; $display("FAIL lu_next got pc=%h v=%0b exp 24/1", o_pc, o_valid); end
        i_valid = 0; tick();
    endtask

    task automatic test_backpressure();
        idle_inputs(); pulse_clr();
        i_valid = 1; i_pc = 32'h40; i_instr = 32'hC0;
        tick();
        i_ready = 0; i_pc = 32'h44; i_instr = 32'hC4;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (o_instr !== 32'hC0 || o_ready !== 1'b0 || o_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_%0d got instr=%h rdy=%0b v=%0b exp c0/0/1", k, o_instr, o_ready, o_valid); end
            tick();
        end
        i_ready = 1; #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0b exp 1", o_ready); end
        tick();
        checks++; if (o_instr !== 32'hC4 || o_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL bp_next got instr=%h cnt=%0d exp c4/0", o_instr, o_stall_cnt); end
        i_valid = 0; tick();
    endtask

    task automatic test_flush_reset();
        idle_inputs(); pulse_clr();
        setup_load_use();
        i_valid = 1; i_pc = 32'h60; i_instr = 32'hE0;
        tick();
        i_pc = 32'h64; i_instr = 32'hE4; i_flush = 1; #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %0b exp 0", o_ready); end
        tick();
        i_flush = 0; i_valid = 0; #1;
        checks++; if (o_valid !== 1'b0 || o_hazard !== 1'b0 || o_stall_cnt !== 16'd1) begin
            errors++; $display("FAIL flush_state got v=%0b hz=%0b cnt=%0d exp 0/0/1", o_valid, o_hazard, o_stall_cnt); end
        checks++; if (o_instr !== 32'hE0) begin errors++; $display("FAIL flush_discard got %h exp e0", o_instr); end
        i_valid = 1; i_pc = 32'h80; i_instr = 32'hF0;
        tick();
        i_valid = 0;
        repeat (4) tick();
        checks++; if (o_stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt5 got %0d exp 5", o_stall_cnt); end
        clr = 1; #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %0b exp 0", o_ready); end
        tick();
        checks++; if (o_valid !== 1'b0 || o_hazard !== 1'b0 || o_pc !== '0 || o_instr !== '0 || o_stall_cnt !== '0) begin
            errors++; $display("FAIL clr_midstall got v=%0b hz=%0b pc=%h instr=%h cnt=%0d exp all 0", o_valid, o_hazard, o_pc, o_instr, o_stall_cnt); end
        clr = 0; #1;
    endtask

    task automatic test_saturation();
        idle_inputs(); pulse_clr();
        setup_load_use();
        i_valid = 1; i_pc = 32'h90; i_instr = 32'h11;
        tick();
        i_valid = 0;
        repeat (14) tick();
        checks++; if (s_stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d exp 14", s_stall_cnt); end
        repeat (6) tick();
        checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_small got %0d exp 15", s_stall_cnt); end
        checks++; if (o_stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide got %0d exp 20", o_stall_cnt); end
        pulse_clr();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_alu_fwd();
        test_load_use();
        test_backpressure();
        test_flush_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
